// File: rtl/score_seg_mux.sv
// -----------------------------------------------------------------------------
// score_seg_mux
//
// Game score keeper with a multiplexed 7-segment display driver.
//
// The score is kept as packed BCD and incremented in one cycle with a full
// decimal carry chain. When it reaches all nines it saturates and raises
// overflow. A three-state game FSM (PLAY / PAUSED / OVER) gates the
// increments. Entering OVER captures the high score. In OVER the display
// blinks by blanking all anodes on alternate blink half-periods.
//
// The display scans one digit per REFRESH_DIV clocks. seg/an/dp are
// registered, so they show the digit index, score and blink phase of the
// previous cycle.
//
// Parameters
//   NUM_DIGITS   number of BCD digits / anodes (2..8)
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   BLINK_DIV    clk cycles per blink half-period (>= 2)
//   LZ_BLANK     1 = blank leading zeros, 0 = show every digit
//
// Ports
//   clk        in   master clock
//   clr        in   synchronous active-high reset
//   score_inc  in   one-cycle pulse, +1 to the score (PLAY only)
//   score_clr  in   clear the score and start a new game
//   pause      in   level, holds the game in PAUSED
//   game_over  in   level, ends the game
//   seg        out  {g,f,e,d,c,b,a}, active-low
//   an         out  anode enables, active-low, one-hot
//   dp         out  decimal point, active-low
//   score_bcd  out  current score, digit 0 in the LSBs
//   high_bcd   out  high score
//   overflow   out  score has saturated
//   state      out  00 PLAY, 01 PAUSED, 10 OVER
// -----------------------------------------------------------------------------
module score_seg_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000,
    parameter int LZ_BLANK    = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    score_inc,
    input  logic                    score_clr,
    input  logic                    pause,
    input  logic                    game_over,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] high_bcd,
    output logic                    overflow,
    output logic [1:0]              state
);

    localparam int SCORE_W = 4 * NUM_DIGITS;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int REF_W   = $clog2(REFRESH_DIV);
    localparam int BLK_W   = $clog2(BLINK_DIV);

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'b00,
        ST_PAUSED = 2'b01,
        ST_OVER   = 2'b10
    } state_t;

    // -------------------------------------------------------------------------
    // Registers and internal nets
    // -------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic                 w_enter_over;
    logic                 w_inc_ok;

    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   r_high;
    logic                 r_overflow;
    logic [SCORE_W-1:0]   w_score_plus1;
    logic                 w_all_nines;

    logic [REF_W-1:0]     r_refresh_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic                 w_refresh_wrap;

    logic [BLK_W-1:0]     r_blink_cnt;
    logic                 r_bp;
    logic                 w_blink_wrap;
    logic                 w_stay_over;

    logic [3:0]           w_digit;
    logic                 w_blank;
    logic [6:0]           w_seg_next;
    logic [NUM_DIGITS-1:0] w_an_next;
    logic                 w_dp_next;

    logic [6:0]           r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                 r_dp;

    // Active-low 7-segment pattern {g,f,e,d,c,b,a} for one BCD digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // -------------------------------------------------------------------------
    // Game FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_PLAY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal written here is given a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_PLAY: begin
                // game_over beats pause
                if (game_over)  w_state_next = ST_OVER;
                else if (pause) w_state_next = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (game_over)   w_state_next = ST_OVER;
                else if (!pause) w_state_next = ST_PLAY;
            end
            ST_OVER: begin
                if (score_clr) w_state_next = ST_PLAY;
            end
            default: w_state_next = ST_PLAY;
        endcase

        // High-score capture is tied to the entry edge only, so it happens
        // once per game even if game_over stays high.
        w_enter_over = (r_state != ST_OVER) && (w_state_next == ST_OVER);
        // score_clr wins over score_inc; increments only count in PLAY.
        w_inc_ok     = score_inc && !score_clr && (r_state == ST_PLAY);
        // The blink logic runs only on edges that begin and end in OVER.
        w_stay_over  = (r_state == ST_OVER) && (w_state_next == ST_OVER);
    end

    // -------------------------------------------------------------------------
    // Score: single-cycle BCD increment with ripple carry
    // -------------------------------------------------------------------------
    always_comb begin
        logic carry;
        w_score_plus1 = r_score;
        w_all_nines   = 1'b1;
        carry         = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_score[4*i +: 4] != 4'd9) begin
                w_all_nines = 1'b0;
            end
            if (carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_score_plus1[4*i +: 4] = 4'd0;
                end else begin
                    w_score_plus1[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr || score_clr) begin
            r_score    <= '0;
            r_overflow <= 1'b0;
        end else if (w_inc_ok) begin
            // At all nines the score holds and overflow latches.
            if (w_all_nines) begin
                r_overflow <= 1'b1;
            end else begin
                r_score <= w_score_plus1;
            end
        end
    end

    // Packed BCD compares correctly as a plain unsigned binary value, because
    // each nibble is a decimal digit in place-value order.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_high <= '0;
        end else if (w_enter_over && (r_score > r_high)) begin
            r_high <= r_score;
        end
    end

    // -------------------------------------------------------------------------
    // Refresh counter and digit index; these run in every state.
    // -------------------------------------------------------------------------
    assign w_refresh_wrap = (r_refresh_cnt == REF_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_refresh_cnt <= '0;
            r_idx         <= '0;
        end else if (w_refresh_wrap) begin
            r_refresh_cnt <= '0;
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Blink counter and phase. Both are cleared on any edge whose result is
    // not a continued OVER, so they read zero whenever the state is not OVER
    // and each game-over starts with the display lit.
    // -------------------------------------------------------------------------
    assign w_blink_wrap = (r_blink_cnt == BLK_W'(BLINK_DIV - 1));

    always_ff @(posedge clk) begin
        if (clr || !w_stay_over) begin
            r_blink_cnt <= '0;
            r_bp        <= 1'b0;
        end else if (w_blink_wrap) begin
            r_blink_cnt <= '0;
            r_bp        <= ~r_bp;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Display next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        logic zero_run;
        w_digit  = 4'd0;
        w_blank  = 1'b0;
        zero_run = 1'b1;
        // Walk from the most significant digit down. zero_run stays true while
        // this digit and every digit above it are zero, which is exactly the
        // leading-zero condition. Digit 0 is never blanked.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (r_score[4*i +: 4] == 4'd0);
            if (r_idx == IDX_W'(i)) begin
                w_digit = r_score[4*i +: 4];
                w_blank = zero_run && (i != 0) && (LZ_BLANK != 0);
            end
        end

        w_seg_next = w_blank ? SEG_BLANK : seg_decode(w_digit);
        w_an_next  = r_bp ? '1 : ~(NUM_DIGITS'(1) << r_idx);
        w_dp_next  = !((r_state == ST_PAUSED) && (r_idx == '0));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_seg <= SEG_ZERO;
            r_an  <= ~NUM_DIGITS'(1);
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
            r_dp  <= w_dp_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign seg       = r_seg;
    assign an        = r_an;
    assign dp        = r_dp;
    assign score_bcd = r_score;
    assign high_bcd  = r_high;
    assign overflow  = r_overflow;
    assign state     = r_state;

endmodule

// File: doc/score_seg_mux.md
SCORE_SEG_MUX -- requirements
Module: score_seg_mux

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4: number of BCD digits and anodes, legal range 2..8.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot, at least 2.
REQ-003 The block SHALL have parameter BLINK_DIV, default 25000000: clk cycles per blink half-period, at least 2.
REQ-004 The block SHALL have parameter LZ_BLANK, default 1: 1 blanks leading zeros, 0 shows all digits.
REQ-005 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single master clock
- clr  in  1  synchronous active-high reset
- score_inc  in  1  one-cycle pulse that adds 1 to the score
- score_clr  in  1  clears the score and starts a new game
- pause  in  1  level; 1 holds the game in PAUSED
- game_over  in  1  level; 1 ends the game
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- an  out  NUM_DIGITS  anode enables, active-low, one-hot
- dp  out  1  decimal point, active-low
- score_bcd  out  4*NUM_DIGITS  current score, digit 0 in the LSBs
- high_bcd  out  4*NUM_DIGITS  high score
- overflow  out  1  score has saturated
- state  out  2  00 PLAY, 01 PAUSED, 10 OVER

Function
REQ-006 The FSM SHALL have three states, with transitions evaluated every clk:
- PLAY -> OVER when game_over=1; game_over beats pause.
- PLAY -> PAUSED when pause=1 and game_over=0.
- PAUSED -> OVER when game_over=1.
- PAUSED -> PLAY when pause=0 and game_over=0.
- OVER -> PLAY only when score_clr=1.
REQ-007 Input priority SHALL be clr > score_clr > score_inc.
REQ-008 score_clr SHALL zero score_bcd and overflow on the next edge in any state, and SHALL leave high_bcd unchanged.
REQ-009 score_inc SHALL be counted only when the state is PLAY.
REQ-010 score_inc SHALL be ignored in PAUSED and OVER, and whenever score_clr=1 in the same cycle.
REQ-011 Increment SHALL be decimal with the full carry chain resolved in one cycle; score_bcd SHALL update on the edge that samples score_inc (1-cycle latency).
REQ-012 At all-nines, an increment SHALL leave the score unchanged and set overflow=1; overflow SHALL stay 1 until score_clr or clr.
REQ-013 On the edge that enters OVER, high_bcd SHALL load score_bcd if score_bcd is greater than high_bcd, compared as unsigned decimal; otherwise high_bcd SHALL hold.
REQ-014 High-score capture SHALL occur exactly once per entry into OVER.
REQ-015 A refresh counter SHALL count 0..REFRESH_DIV-1 and then wrap.
REQ-016 On each refresh wrap, digit index idx SHALL advance by 1 modulo NUM_DIGITS, so idx NUM_DIGITS-1 wraps to 0.
REQ-017 The refresh counter and idx SHALL run in all states, including PAUSED.
REQ-018 seg, an and dp SHALL be registered: they reflect idx, the score and the blink phase as of the previous cycle.
REQ-019 an SHALL drive bit idx low and all other bits high.
REQ-020 seg SHALL be the active-low pattern of score digit idx. Required patterns:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-021 When LZ_BLANK=1, seg SHALL be 1111111 for digit idx if idx is not 0 and digit idx and every higher digit are all 0.
REQ-022 In OVER, a blink counter of BLINK_DIV cycles SHALL toggle blink phase bp at each wrap; while bp=1, an SHALL be all ones.
REQ-023 The blink counter and bp SHALL be zero whenever the state is not OVER.
REQ-024 dp SHALL be 0 when the state is PAUSED and idx=0, and 1 otherwise.

Reset
REQ-025 While clr=1 on an edge, the block SHALL set:
- score_bcd=0, high_bcd=0, overflow=0, state=PLAY
- refresh counter=0, idx=0, blink counter=0, bp=0
- seg=1000000, an=~1 (1110 when NUM_DIGITS=4), dp=1
REQ-026 clr asserted mid-operation, including mid-blink or mid-refresh, SHALL override every other input on that edge.

Verification
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=8, LZ_BLANK=1.
REQ-027 Reset: apply clr for 1 cycle -> score_bcd=0x0000, an=1110, seg=1000000, dp=1, state=00.
REQ-028 Counting and carry:
- 9 score_inc pulses -> 0x0009; one more pulse -> 0x0010.
- Display: the digit-1 slot shows seg=1111001 and the digit-2 and digit-3 slots show 1111111.
REQ-029 Saturation: preload the score to 9999 by pulses, apply one more score_inc -> score stays 0x9999 and overflow=1; then score_clr -> 0x0000 and overflow=0.
REQ-030 Pause:
- pause=1 then 3 score_inc pulses -> score unchanged, state=01, dp=0 only in the idx=0 slot.
- pause=0 -> state=00.
- Applying pause=1 and game_over=1 together -> state=10.
REQ-031 High score:
- Score 0x0042, game_over -> high_bcd=0x0042 and an all ones for 8 of every 16 cycles.
- score_clr, then 5 pulses, then game_over -> high_bcd stays 0x0042.
REQ-032 Simultaneous inputs: score_clr and score_inc in the same cycle in PLAY -> score 0x0000; clr mid-OVER -> state=00 and bp=0 on the next edge.
